// File: rtl/gpu_pkg.sv
// ----------------------------------------------------------------------------
// gpu_pkg
// Shared types and constants for the GPU control sequencer.
//   seq_state_t : sequencer FSM states (4-bit encoding)
//   OP_IDX_W    : width of the operand index bus
// ----------------------------------------------------------------------------
package gpu_pkg;

   localparam int OP_IDX_W = 4;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      SHIFT      = 4'd1,
      GET        = 4'd2,
      NEWSHAPE   = 4'd3,
      OUTPUTWAIT = 4'd4,
      DATAOUTPUT = 4'd5,
      DATASENT   = 4'd6,
      OUTPUTEND  = 4'd7
   } seq_state_t;

endpackage

// File: rtl/gpu_sequencer_if.sv
// ----------------------------------------------------------------------------
// gpu_sequencer_if
// Bundles the command FIFO, rasteriser and bus-master handshake signals of
// the GPU sequencer.
//   master modport : the sequencer (drives strobes, op_index, px_count)
//   slave modport  : the surrounding FIFO / rasteriser / bus master
// Parameter PX_CNT_W sets the px_count width.
// ----------------------------------------------------------------------------
interface gpu_sequencer_if #(
   parameter int PX_CNT_W = 16
) ();
   import gpu_pkg::*;

   // Environment -> sequencer
   logic                busy;
   logic                data_ready;
   logic                shape_done;
   logic                master_busy;
   // Sequencer -> environment
   logic                read;
   logic                shift_enable;
   logic [OP_IDX_W-1:0] op_index;
   logic                new_shape;
   logic                send_data;
   logic                busy_reset;
   logic [PX_CNT_W-1:0] px_count;
   logic                timeout_err;

   modport master (
      input  busy, data_ready, shape_done, master_busy,
      output read, shift_enable, op_index, new_shape, send_data,
             busy_reset, px_count, timeout_err
   );

   modport slave (
      output busy, data_ready, shape_done, master_busy,
      input  read, shift_enable, op_index, new_shape, send_data,
             busy_reset, px_count, timeout_err
   );

endinterface

// File: rtl/gpu_sat_counter.sv
// ----------------------------------------------------------------------------
// gpu_sat_counter
// Up-counter with synchronous clear and saturating increment.
//   clk     : system clock
//   reset   : synchronous, active-high reset (count -> 0)
//   i_clr   : clear to 0 (wins over i_inc)
//   i_inc   : increment by one, holding at all-ones
//   o_count : current count
// ----------------------------------------------------------------------------
module gpu_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/gpu_sequencer.sv
// ----------------------------------------------------------------------------
// gpu_sequencer
// GPU control sequencer: shifts NUM_OPS operands out of the command FIFO,
// launches one shape, streams every ready pixel to the bus master and then
// releases the command busy flag.
//
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : gpu_sequencer_if.master (busy/data_ready/shape_done/master_busy
//           in; read/shift_enable/op_index/new_shape/send_data/busy_reset/
//           px_count/timeout_err out)
//
// Parameters: NUM_OPS (2..15), PX_CNT_W, TIMEOUT_CYCLES.
// Build option: define GPU_TIMEOUT_EN to add a watchdog that aborts a shape
// after TIMEOUT_CYCLES consecutive cycles in OUTPUTWAIT/DATAOUTPUT; without
// it timeout_err is tied low.
// ----------------------------------------------------------------------------
module gpu_sequencer
   import gpu_pkg::*;
#(
   parameter int NUM_OPS        = 3,
   parameter int PX_CNT_W       = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic           clk,
   input  logic           reset,
   gpu_sequencer_if.master bus
);

   localparam logic [OP_IDX_W-1:0] LAST_OP = OP_IDX_W'(NUM_OPS - 1);

   seq_state_t          r_state;
   seq_state_t          w_next_state;
   logic [OP_IDX_W-1:0] r_op_cnt;
   logic [PX_CNT_W-1:0] w_px_count;

`ifdef GPU_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WD_W-1:0] w_wd_count;
   logic            w_wd_expired;
   logic            w_timeout_hit;
   logic            r_timeout;

   assign w_wd_expired = (w_wd_count == WD_W'(TIMEOUT_CYCLES - 1));
`endif

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path through this block leaves
      // w_next_state unassigned, which would otherwise infer a latch.
      w_next_state = IDLE;
      case (r_state)
         IDLE:       w_next_state = bus.busy ? SHIFT : IDLE;
         SHIFT:      w_next_state = (r_op_cnt == LAST_OP) ? NEWSHAPE : GET;
         GET:        w_next_state = SHIFT;
         NEWSHAPE:   w_next_state = OUTPUTWAIT;
         OUTPUTWAIT: begin
            // shape_done outranks a pending pixel
            if (bus.shape_done)      w_next_state = OUTPUTEND;
            else if (bus.data_ready) w_next_state = DATAOUTPUT;
            else                     w_next_state = OUTPUTWAIT;
         end
         DATAOUTPUT: w_next_state = bus.master_busy ? DATAOUTPUT : DATASENT;
         DATASENT:   w_next_state = OUTPUTWAIT;
         OUTPUTEND:  w_next_state = IDLE;
         default:    w_next_state = IDLE;   // illegal encodings recover
      endcase

`ifdef GPU_TIMEOUT_EN
      // The watchdog only fires when the FSM would otherwise stay put, so a
      // real transition in the same cycle always wins.
      w_timeout_hit = 1'b0;
      if (w_wd_expired && (w_next_state == r_state) &&
          ((r_state == OUTPUTWAIT) || (r_state == DATAOUTPUT))) begin
         w_next_state  = OUTPUTEND;
         w_timeout_hit = 1'b1;
      end
`endif
   end

   // State register and operand counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_op_cnt <= '0;
`ifdef GPU_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
      end else begin
         r_state <= w_next_state;
         if (r_state == SHIFT) begin
            r_op_cnt <= (r_op_cnt == LAST_OP) ? '0 : r_op_cnt + 1'b1;
         end
`ifdef GPU_TIMEOUT_EN
         // High only during the OUTPUTEND cycle entered by a timeout
         r_timeout <= w_timeout_hit;
`endif
      end
   end

   // Pixel counter: cleared while launching a shape, bumped once per pixel
   gpu_sat_counter #(
      .WIDTH (PX_CNT_W)
   ) u_px_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (r_state == NEWSHAPE),
      .i_inc   (r_state == DATASENT),
      .o_count (w_px_count)
   );

`ifdef GPU_TIMEOUT_EN
   // Watchdog: restarts on every state change, counts dwell in the two
   // states that wait on the rasteriser or the bus master.
   gpu_sat_counter #(
      .WIDTH (WD_W)
   ) u_wd_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_next_state != r_state),
      .i_inc   ((r_state == OUTPUTWAIT) || (r_state == DATAOUTPUT)),
      .o_count (w_wd_count)
   );

   assign bus.timeout_err = r_timeout;
`else
   assign bus.timeout_err = 1'b0;
`endif

   // Moore outputs, decoded from the state register only
   assign bus.shift_enable = (r_state == SHIFT);
   assign bus.op_index     = (r_state == SHIFT) ? r_op_cnt : '0;
   assign bus.read         = (r_state == GET);
   assign bus.new_shape    = (r_state == NEWSHAPE);
   assign bus.send_data    = (r_state == DATASENT);
   assign bus.busy_reset   = (r_state == OUTPUTEND);
   assign bus.px_count     = w_px_count;

endmodule

// File: tb/tb_gpu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gpu_sequencer
// Two sequencers (NUM_OPS=3 and NUM_OPS=5) driven by cycle-scripted command,
// rasteriser and bus-master behaviour. Each command's expected strobe events
// (kind, value, cycle) are derived from the protocol timing rules and queued;
// a negedge monitor per DUT pops and compares every strobe it sees.
// ----------------------------------------------------------------------------
module tb_gpu_sequencer;
   import gpu_pkg::*;

   localparam int PXW = 16;
   localparam int TO  = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst[2];
   logic d_busy[2];
   logic d_ready[2];
   logic d_done[2];
   logic d_mbusy[2];
   bit   mon_en = 1'b0;

   gpu_sequencer_if #(.PX_CNT_W(PXW)) if0 ();
   gpu_sequencer_if #(.PX_CNT_W(PXW)) if1 ();

   assign if0.busy        = d_busy[0];
   assign if0.data_ready  = d_ready[0];
   assign if0.shape_done  = d_done[0];
   assign if0.master_busy = d_mbusy[0];
   assign if1.busy        = d_busy[1];
   assign if1.data_ready  = d_ready[1];
   assign if1.shape_done  = d_done[1];
   assign if1.master_busy = d_mbusy[1];

   gpu_sequencer #(.NUM_OPS(3), .PX_CNT_W(PXW), .TIMEOUT_CYCLES(TO)) u_dut3 (
      .clk (clk), .reset (rst[0]), .bus (if0.master)
   );
   gpu_sequencer #(.NUM_OPS(5), .PX_CNT_W(PXW), .TIMEOUT_CYCLES(TO)) u_dut5 (
      .clk (clk), .reset (rst[1]), .bus (if1.master)
   );

   typedef enum int {EV_SHIFT, EV_READ, EV_NEW, EV_SEND, EV_BRST, EV_TERR} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       val;
      int       cyc;
   } ev_t;

   ev_t exp_q[2][$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  gap_a[16];
   int  stall_a[16];

   task automatic check(input string name, input bit ok, input string got, input string want);
      n_checks++;
      if (ok) n_pass++;
      else    $display("FAIL %s: got %s, expected %s", name, got, want);
   endtask

   task automatic push(input int g, input ev_kind_t k, input int v, input int c);
      exp_q[g].push_back('{kind: k, val: v, cyc: c});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   task automatic mon_ev(input int g, input ev_kind_t k, input int v);
      ev_t e;
      if (exp_q[g].size() == 0) begin
         check($sformatf("dut%0d_unexpected", g), 1'b0,
               $sformatf("%s val=%0d cyc=%0d", k.name(), v, cyc), "no event");
      end else begin
         e = exp_q[g].pop_front();
         check($sformatf("dut%0d_%s", g, e.kind.name()),
               (e.kind == k) && (e.val == v) && (e.cyc == cyc),
               $sformatf("%s val=%0d cyc=%0d", k.name(), v, cyc),
               $sformatf("%s val=%0d cyc=%0d", e.kind.name(), e.val, e.cyc));
      end
   endtask

   task automatic mon_dut(input int g, input logic rd, input logic sh,
                          input logic [OP_IDX_W-1:0] oi, input logic ns,
                          input logic sd, input logic br,
                          input logic [PXW-1:0] px, input logic te);
      if (sh === 1'b1) mon_ev(g, EV_SHIFT, int'(oi));
      if (rd === 1'b1) mon_ev(g, EV_READ, 0);
      if (ns === 1'b1) mon_ev(g, EV_NEW, 0);
      if (sd === 1'b1) mon_ev(g, EV_SEND, 0);
      if (br === 1'b1) mon_ev(g, EV_BRST, int'(px));
      if (te === 1'b1) mon_ev(g, EV_TERR, 0);
   endtask

   always @(negedge clk) if (mon_en)
      mon_dut(0, if0.read, if0.shift_enable, if0.op_index, if0.new_shape,
              if0.send_data, if0.busy_reset, if0.px_count, if0.timeout_err);
   always @(negedge clk) if (mon_en)
      mon_dut(1, if1.read, if1.shift_enable, if1.op_index, if1.new_shape,
              if1.send_data, if1.busy_reset, if1.px_count, if1.timeout_err);

   // All outputs quiet and px_count zero
   task automatic chk_quiet(input int g, input string name);
      logic [6:0]          strobes;
      logic [OP_IDX_W-1:0] oi;
      logic [PXW-1:0]      px;
      if (g == 0) begin
         strobes = {if0.read, if0.shift_enable, if0.new_shape, if0.send_data,
                    if0.busy_reset, if0.timeout_err, 1'b0};
         oi = if0.op_index;
         px = if0.px_count;
      end else begin
         strobes = {if1.read, if1.shift_enable, if1.new_shape, if1.send_data,
                    if1.busy_reset, if1.timeout_err, 1'b0};
         oi = if1.op_index;
         px = if1.px_count;
      end
      check($sformatf("%s_dut%0d", name, g), (strobes === '0) && (oi === '0) && (px === '0),
            $sformatf("strobes=%b op_index=%0d px_count=%0d", strobes, oi, px),
            "strobes=0000000 op_index=0 px_count=0");
   endtask

   // ---------------- reference model + driver ----------------
   // Command phase: shift k at c0+1+2k, read between shifts, new_shape at
   // c0+2*nops.
   task automatic push_cmd(input int g, input int nops, input int c0);
      for (int k = 0; k < nops; k++) begin
         push(g, EV_SHIFT, k, c0 + 1 + 2 * k);
         if (k < nops - 1) push(g, EV_READ, 0, c0 + 2 + 2 * k);
      end
      push(g, EV_NEW, 0, c0 + 2 * nops);
   endtask

   // Pixel p costs 3 cycles plus its data_ready gap plus its master_busy
   // stall; shape_done right after the last pixel gives busy_reset two
   // cycles after that pixel. abort_px >= 0 resets the DUT mid-pixel.
   task automatic run_cmd(input int g, input int nops, input int npx,
                          input bit dual, input int abort_px, input bit keep_busy);
      int c0;
      int prev;
      c0   = cyc;
      prev = c0 + 2 * nops;
      push_cmd(g, nops, c0);
      for (int p = 0; p < npx; p++) begin
         if (p == abort_px) break;
         prev = prev + 3 + gap_a[p] + stall_a[p];
         push(g, EV_SEND, 0, prev);
      end
      if (abort_px < 0) push(g, EV_BRST, npx, prev + 2);

      d_busy[g] = 1'b1;
      tick();
      d_busy[g] = 1'b0;
      repeat (2 * nops - 1) tick();
      for (int p = 0; p < npx; p++) begin
         tick();
         repeat (gap_a[p]) tick();
         d_ready[g] = 1'b1;
         tick();
         d_ready[g] = 1'b0;
         if (p == abort_px) begin
            d_mbusy[g] = 1'b1;
            tick();
            rst[g] = 1'b1;
            tick();
            rst[g]     = 1'b0;
            d_mbusy[g] = 1'b0;
            chk_quiet(g, "reset_mid_shape");
            check($sformatf("abort_pending_dut%0d", g), exp_q[g].size() == 0,
                  $sformatf("%0d", exp_q[g].size()), "0");
            return;
         end
         d_mbusy[g] = 1'b1;
         repeat (stall_a[p]) tick();
         d_mbusy[g] = 1'b0;
         tick();
      end
      tick();
      d_done[g]  = 1'b1;
      d_ready[g] = dual;
      tick();
      d_done[g]  = 1'b0;
      d_ready[g] = 1'b0;
      if (keep_busy) d_busy[g] = 1'b1;
      tick();
   endtask

   // Rasteriser stays silent after new_shape.
   task automatic run_silent(input int g, input int nops);
      int c0;
      int s;
      c0 = cyc;
      s  = c0 + 2 * nops;
      push_cmd(g, nops, c0);
`ifdef GPU_TIMEOUT_EN
      push(g, EV_BRST, 0, s + 1 + TO);
      push(g, EV_TERR, 0, s + 1 + TO);
`endif
      d_busy[g] = 1'b1;
      tick();
      d_busy[g] = 1'b0;
      repeat (2 * nops - 1) tick();
`ifdef GPU_TIMEOUT_EN
      repeat (TO + 1) tick();
      tick();
`else
      repeat (40) tick();
      check($sformatf("silent_pending_dut%0d", g), exp_q[g].size() == 0,
            $sformatf("%0d", exp_q[g].size()), "0");
      push(g, EV_BRST, 0, s + 41);
      d_done[g] = 1'b1;
      tick();
      d_done[g] = 1'b0;
      tick();
`endif
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int  g;
      int  npx;
      bit  keep;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; d_busy[i] = 1'b0; d_ready[i] = 1'b0;
         d_done[i] = 1'b0; d_mbusy[i] = 1'b0;
      end
      repeat (3) tick();
      chk_quiet(0, "reset_state");
      chk_quiet(1, "reset_state");
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      mon_en = 1'b1;
      tick();
      chk_quiet(0, "post_reset_idle");

      // 4 pixels, master_busy held 3 cycles on pixel 2
      for (int i = 0; i < 16; i++) begin gap_a[i] = 0; stall_a[i] = 0; end
      stall_a[1] = 3;
      run_cmd(0, 3, 4, 1'b0, -1, 1'b0);
      // shape_done and data_ready together
      stall_a[1] = 0;
      run_cmd(0, 3, 2, 1'b1, -1, 1'b0);
      // reset while stalled in DATAOUTPUT on the second pixel, then restart
      run_cmd(0, 3, 3, 1'b0, 1, 1'b0);
      run_cmd(0, 3, 1, 1'b0, -1, 1'b0);
      // five operands
      run_cmd(1, 5, 2, 1'b0, -1, 1'b0);
      // silent rasteriser
      run_silent(0, 3);
      run_silent(1, 5);

      // randomized commands
      g = 0;
      keep = 1'b0;
      repeat (30) begin
         if (!keep) g = int'($urandom_range(0, 1));
         npx = int'($urandom_range(0, 6));
         for (int i = 0; i < 16; i++) begin
            gap_a[i]   = int'($urandom_range(0, 6));
            stall_a[i] = int'($urandom_range(0, 5));
         end
         keep = 1'($urandom_range(0, 1));
         run_cmd(g, (g == 0) ? 3 : 5, npx, 1'($urandom_range(0, 1)), -1, keep);
         if (!keep) repeat (int'($urandom_range(0, 3))) tick();
      end
      d_busy[0] = 1'b0;
      d_busy[1] = 1'b0;
      if (keep) run_cmd(g, (g == 0) ? 3 : 5, 0, 1'b0, -1, 1'b0);
      repeat (5) tick();
      for (int i = 0; i < 2; i++)
         check($sformatf("final_pending_dut%0d", i), exp_q[i].size() == 0,
               $sformatf("%0d", exp_q[i].size()), "0");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
